// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Latches the winning byte, strobes the transmitter, acks on frame start, counts completed frames.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                          clk_arb,
    input  logic                          rst_arb,
    input  logic [N_REQ-1:0]              req_valid_arb,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_arb,
    output logic [N_REQ-1:0]              req_ack_arb,
    input  logic                          tx_busy_arb,
    output logic                          tx_data_valid_arb,
    output logic [DATA_WIDTH-1:0]         tx_p_data_arb,
    output logic [$clog2(N_REQ)-1:0]      grant_id_arb,
    output logic                          timeout_err_arb,
    output logic [15:0]                   frame_count_arb
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [GW-1:0]           ptr_reg;
    logic [CW-1:0]           cnt_reg;
    logic [DATA_WIDTH-1:0]   req_bytes [N_REQ];
    logic [N_REQ-1:0]        grant_onehot;
    logic [GW-1:0]           winner;
    logic                    arb_req;
    logic                    start_expired;
    logic                    tx_valid_next;
    logic [N_REQ-1:0]        ack_next;
    logic                    timeout_next;

    // Index arithmetic modulo N_REQ; N_REQ need not be a power of two.
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N_REQ) s = s - N_REQ;
        return GW'(s);
    endfunction

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_bytes[gi]    = req_data_arb[gi*DATA_WIDTH +: DATA_WIDTH];
            assign grant_onehot[gi] = (grant_id_arb == GW'(gi));
        end
    endgenerate

    // Scan from the far end back toward ptr so the closest asserted index wins.
    always_comb begin
        winner = ptr_reg;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_arb[wrap_add(ptr_reg, k)]) winner = wrap_add(ptr_reg, k);
        end
    end

    assign arb_req       = !tx_busy_arb && (|req_valid_arb);
    assign start_expired = (cnt_reg == CW'(START_TIMEOUT - 1));

    always_ff @(posedge clk_arb or posedge rst_arb) begin
        if (rst_arb) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (arb_req) state_next = ISSUE;
            ISSUE:      state_next = WAIT_START;
            WAIT_START: begin
                if (tx_busy_arb)        state_next = WAIT_DONE;
                else if (start_expired) state_next = IDLE;
            end
            WAIT_DONE:  if (!tx_busy_arb) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_valid_next = 1'b0;
        ack_next      = '0;
        timeout_next  = 1'b0;
        case (state_reg)
            IDLE:       tx_valid_next = arb_req;
            WAIT_START: begin
                if (tx_busy_arb)        ack_next     = grant_onehot;
                else if (start_expired) timeout_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_arb or posedge rst_arb) begin
        if (rst_arb) begin
            tx_data_valid_arb <= 1'b0;
            req_ack_arb       <= '0;
            timeout_err_arb   <= 1'b0;
            tx_p_data_arb     <= '0;
            grant_id_arb      <= '0;
            frame_count_arb   <= '0;
            ptr_reg           <= '0;
            cnt_reg           <= '0;
        end else begin
            tx_data_valid_arb <= tx_valid_next;
            req_ack_arb       <= ack_next;
            timeout_err_arb   <= timeout_next;
            if (state_reg == IDLE && arb_req) begin
                tx_p_data_arb <= req_bytes[winner];
                grant_id_arb  <= winner;
            end
            if (state_reg == ISSUE)           cnt_reg <= '0;
            else if (state_reg == WAIT_START) cnt_reg <= cnt_reg + CW'(1);
            // Busy falling ends the frame regardless of line errors; rotate past the grantee.
            if (state_reg == WAIT_DONE && !tx_busy_arb) begin
                frame_count_arb <= frame_count_arb + 16'd1;
                ptr_reg         <= wrap_add(grant_id_arb, 1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences and randomized traffic
// checked against a round-robin reference model and a behavioural transmitter stub.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int ST = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ack;
    logic              tx_busy = 1'b0;
    logic              tx_dv;
    logic [DW-1:0]     tx_data;
    logic [1:0]        grant;
    logic              tout;
    logic [15:0]       fc;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .START_TIMEOUT(ST)) dut (
        .clk_arb(clk), .rst_arb(rst),
        .req_valid_arb(req_valid), .req_data_arb(req_data), .req_ack_arb(req_ack),
        .tx_busy_arb(tx_busy), .tx_data_valid_arb(tx_dv), .tx_p_data_arb(tx_data),
        .grant_id_arb(grant), .timeout_err_arb(tout), .frame_count_arb(fc)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter stub: 0 = manual busy, 1 = fixed delay/length, 2 = random delay/length.
    int stub_mode  = 0;
    int stub_delay = 2;
    int stub_len   = 3;
    initial begin
        int to_rise;
        int to_fall;
        int len_sel;
        to_rise = -1; to_fall = 0; len_sel = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_busy = 1'b0; to_rise = -1; to_fall = 0;
            end else if (stub_mode != 0) begin
                if (to_fall > 0) begin
                    to_fall--;
                    if (to_fall == 0) tx_busy = 1'b0;
                end
                if (to_rise > 0) begin
                    to_rise--;
                    if (to_rise == 0) begin tx_busy = 1'b1; to_fall = len_sel; to_rise = -1; end
                end
                if (tx_dv) begin
                    to_rise = (stub_mode == 2) ? int'($urandom_range(1, 4)) : stub_delay;
                    len_sel = (stub_mode == 2) ? int'($urandom_range(1, 6)) : stub_len;
                end
            end
        end
    end

    // Reference model: winner is the first requester at or after the rotation point.
    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        logic [N-1:0]    v_s;
        logic [N*DW-1:0] d_s;
        int              exp_ptr;
        int              exp_g;
        int              last_g;
        logic [DW-1:0]   last_d;
        bit              owed;
        exp_ptr = 0; last_g = 0; last_d = '0; owed = 0;
        forever begin
            @(posedge clk);
            v_s = req_valid;
            d_s = req_data;
            @(negedge clk);
            if (rst) begin
                exp_ptr = 0; owed = 0;
            end else begin
                if (tx_dv) begin
                    exp_g = rr_pick(v_s, exp_ptr);
                    if (exp_g < 0) check("model_strobe_without_request", 1, 0);
                    else begin
                        check("model_grant", grant, exp_g);
                        check("model_byte", tx_data, d_s[exp_g*DW +: DW]);
                        last_g = exp_g;
                        last_d = d_s[exp_g*DW +: DW];
                    end
                    owed = 1;
                end
                if (req_ack != '0) begin
                    check("model_ack_vector", req_ack, 1 << last_g);
                    check("model_ack_owed", owed, 1);
                    check("model_byte_stable", tx_data, last_d);
                    owed = 0;
                    exp_ptr = (last_g + 1) % N;
                end
                if (tout) owed = 0;
            end
        end
    end

    task automatic wait_strobe(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_dv) begin seen = 1; break; end
        end
        check({name, "_strobe_seen"}, seen, 1);
    endtask

    task automatic wait_ack(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ack != '0) begin seen = 1; break; end
        end
        check({name, "_ack_seen"}, seen, 1);
    endtask

    task automatic wait_fc(input string name, input logic [15:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fc == target) break;
        end
        check({name, "_frame_count"}, fc, target);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack"}, req_ack, 0);
        check({name, "_strobe"}, tx_dv, 0);
        check({name, "_data"}, tx_data, 0);
        check({name, "_grant"}, grant, 0);
        check({name, "_timeout"}, tout, 0);
        check({name, "_frame_count"}, fc, 0);
    endtask

    typedef struct {
        logic [N-1:0]    mask;
        logic [N*DW-1:0] data;
        int              exp_grant;
        logic [DW-1:0]   exp_byte;
    } vec_t;

    vec_t tbl[11];

    task automatic drive_random(input bit allow);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ack[i]) req_valid[i] = 1'b0;
            else if (!req_valid[i]) begin
                if (allow && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end else if ($urandom_range(0, 7) == 0) req_data[i*DW +: DW] = DW'($urandom);
        end
    endtask

    initial begin
        int           k;
        bit           flag;
        bit           flag2;
        int           acks;
        logic [15:0]  fc0;

        tbl[0]  = '{4'b1111, 32'h43322110, 0, 8'h10};
        tbl[1]  = '{4'b1111, 32'h43322110, 1, 8'h21};
        tbl[2]  = '{4'b1111, 32'h43322110, 2, 8'h32};
        tbl[3]  = '{4'b1111, 32'h43322110, 3, 8'h43};
        tbl[4]  = '{4'b1111, 32'h43322110, 0, 8'h10};
        tbl[5]  = '{4'b0001, 32'h000000C1, 0, 8'hC1};
        tbl[6]  = '{4'b1000, 32'hD3000000, 3, 8'hD3};
        tbl[7]  = '{4'b0110, 32'h00E2E100, 1, 8'hE1};
        tbl[8]  = '{4'b1001, 32'hF40000F0, 3, 8'hF4};
        tbl[9]  = '{4'b0100, 32'h00550000, 2, 8'h55};
        tbl[10] = '{4'b0011, 32'h00006766, 0, 8'h66};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Vector table: one frame per row with the fixed-latency stub.
        stub_mode = 1; stub_delay = 3; stub_len = 4;
        for (int r = 0; r < 11; r++) begin
            req_valid = tbl[r].mask;
            req_data  = tbl[r].data;
            wait_strobe($sformatf("row%0d", r), 20);
            check($sformatf("row%0d_grant", r), grant, tbl[r].exp_grant);
            check($sformatf("row%0d_byte", r), tx_data, tbl[r].exp_byte);
            wait_ack($sformatf("row%0d", r), 30);
            check($sformatf("row%0d_ack", r), req_ack, 1 << tbl[r].exp_grant);
            req_valid = '0;
            wait_fc($sformatf("row%0d", r), 16'(r + 1), 30);
        end

        // Reset asserted while the transmitter is mid-frame.
        stub_len = 12;
        req_valid = 4'b0100; req_data = 32'h00990000;
        wait_strobe("midrst", 20);
        wait_ack("midrst", 30);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stub_len = 3;
        req_valid = 4'b0001; req_data = 32'h0000005A;
        wait_strobe("post_rst", 20);
        check("post_rst_byte", tx_data, 8'h5A);
        check("post_rst_grant", grant, 0);
        wait_ack("post_rst", 30);
        req_valid = '0;
        wait_fc("post_rst", 16'd1, 30);

        // Busy already high when a request arrives.
        stub_mode = 0; tx_busy = 1'b1;
        req_valid = 4'b0010; req_data = 32'h0000B700;
        flag = 0;
        repeat (6) begin @(negedge clk); if (tx_dv) flag = 1; end
        check("busy_block_no_strobe", flag, 0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_release_strobe", tx_dv, 1);
        check("busy_release_grant", grant, 1);
        tx_busy = 1'b1;
        wait_ack("busy_block", 10);
        req_valid = '0;
        repeat (2) @(negedge clk);
        tx_busy = 1'b0;
        wait_fc("busy_block", 16'd2, 10);

        // Transmitter never starts: timeout, no ack, same requester retried.
        req_valid = 4'b1000; req_data = 32'h77000000;
        wait_strobe("timeout", 10);
        flag = 0; flag2 = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (req_ack != '0) flag2 = 1;
            if (tout) begin flag = 1; break; end
        end
        check("timeout_seen", flag, 1);
        check("timeout_latency", k, ST + 1);
        check("timeout_no_ack", flag2, 0);
        @(negedge clk);
        check("timeout_single_pulse", tout, 0);
        check("timeout_retry_strobe", tx_dv, 1);
        check("timeout_retry_grant", grant, 3);
        tx_busy = 1'b1;
        wait_ack("timeout_retry", 10);
        req_valid = '0;
        repeat (2) @(negedge clk);
        tx_busy = 1'b0;
        wait_fc("timeout_retry", 16'd3, 10);

        // Requester withdraws and changes data right after the grant.
        stub_mode = 1; stub_delay = 2; stub_len = 3;
        req_valid = 4'b0100; req_data = 32'h00A50000;
        wait_strobe("withdraw", 10);
        check("withdraw_byte", tx_data, 8'hA5);
        req_valid = 4'b1011;
        req_data  = 32'h33FF1100;
        wait_ack("withdraw", 20);
        check("withdraw_ack", req_ack, 4'b0100);
        check("withdraw_latched", tx_data, 8'hA5);
        wait_strobe("withdraw_next", 20);
        check("withdraw_next_grant", grant, 3);
        wait_ack("withdraw_next", 20);
        req_valid = '0;
        wait_fc("withdraw_next", 16'd5, 20);

        // Randomized traffic against the reference model.
        stub_mode = 2;
        fc0 = fc; acks = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req_ack != '0) acks++;
            drive_random(1'b1);
        end
        for (int c = 0; c < 600 && req_valid != '0; c++) begin
            @(negedge clk);
            if (req_ack != '0) acks++;
            drive_random(1'b0);
        end
        check("rand_drained", req_valid, 0);
        check("rand_activity", acks > 50, 1);
        wait_fc("rand", 16'(fc0 + 16'(acks)), 30);

        // Counter wrap from a preloaded 0xFFFF.
        stub_mode = 1;
        repeat (3) @(negedge clk);
        force dut.frame_count_arb = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_arb;
        @(negedge clk);
        check("wrap_preload", fc, 16'hFFFF);
        req_valid = 4'b0001; req_data = 32'h000000E7;
        wait_strobe("wrap", 20);
        wait_ack("wrap", 20);
        req_valid = '0;
        wait_fc("wrap", 16'h0000, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
